// File: rtl/axis_coef_packer_pkg.sv
// axis_coef_packer_pkg: packer state encoding, MDL frame-length constants and defaults.
package axis_coef_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pk_state_t;

  localparam int LEN_KECCAK = 50;
  localparam int LEN_PWM    = 2048;
  localparam int LEN_NTT    = 4096;

  localparam int DEF_DCOEF  = 32;
  localparam int DEF_LANES  = 2;
  localparam int DEF_LEN_W  = $clog2(LEN_NTT) + 1;

  // Lane-counter width; a single-lane packer still needs one bit.
  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/axis_beat_reg.sv
// axis_beat_reg: single-entry AXI-Stream output slice holding valid, data, keep and last.
module axis_beat_reg #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [KEEP_W-1:0] keep,
  output logic              last,
  output logic              free
);

  // Free when empty or draining this cycle; load is only asserted while free.
  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      keep  <= load_keep;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_coef_packer.sv
// axis_coef_packer: packs PRM_LANES coefficients per wide AXIS beat with
// counter-driven TKEEP/TLAST, a one-beat gather buffer and input TLAST checking.
module axis_coef_packer
  import axis_coef_packer_pkg::*;
#(
  parameter int PRM_DCOEF = DEF_DCOEF,
  parameter int PRM_LANES = DEF_LANES,
  parameter int PRM_DAXI  = PRM_DCOEF * PRM_LANES,
  parameter int PRM_LEN_W = DEF_LEN_W
) (
  input  logic                  iSYS_CLK,
  input  logic                  iSYS_RST,
  input  logic                  iCTL_START,
  input  logic [PRM_LEN_W-1:0]  iCTL_LEN,
  output logic                  oCTL_BUSY,
  output logic                  oCTL_DONE,
  output logic                  oCTL_ERR,
  input  logic                  iC_TVALID,
  output logic                  oC_TREADY,
  input  logic [PRM_DCOEF-1:0]  iC_TDATA,
  input  logic                  iC_TLAST,
  output logic                  oM_AXIS_TVALID,
  input  logic                  iM_AXIS_TREADY,
  output logic [PRM_DAXI-1:0]   oM_AXIS_TDATA,
  output logic [PRM_DAXI/8-1:0] oM_AXIS_TKEEP,
  output logic                  oM_AXIS_TLAST
);

  localparam int KEEP_W      = PRM_DAXI / 8;
  localparam int LANE_KEEP_W = PRM_DCOEF / 8;
  localparam int LANE_W      = lane_bits(PRM_LANES);
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(PRM_LANES - 1);
  localparam logic [PRM_LEN_W-1:0] ONE_LEFT  = PRM_LEN_W'(1);

  pk_state_t              state;
  logic [PRM_LEN_W-1:0]   rem;
  logic [LANE_W-1:0]      lane_cnt;
  logic [PRM_DAXI-1:0]    gather_data;
  logic [KEEP_W-1:0]      gather_keep;
  logic                   gather_last;
  logic                   pending;
  logic                   busy_r;
  logic                   done_r;
  logic                   err_r;

  logic                   c_ready;
  logic                   accept;
  logic                   last_coef;
  logic                   beat_done;
  logic                   out_free;
  logic                   load;
  logic                   last_fire;
  logic [PRM_DAXI-1:0]    merged_data;
  logic [KEEP_W-1:0]      merged_keep;
  logic [PRM_DAXI-1:0]    load_data;
  logic [KEEP_W-1:0]      load_keep;
  logic                   load_last;

  assign c_ready   = (state == ST_RUN) && !pending;
  assign accept    = iC_TVALID && c_ready;
  assign last_coef = (rem == ONE_LEFT);
  assign beat_done = accept && ((lane_cnt == LAST_LANE) || last_coef);
  assign last_fire = oM_AXIS_TVALID && iM_AXIS_TREADY && oM_AXIS_TLAST;

  always_comb begin
    merged_data = gather_data;
    merged_keep = gather_keep;
    merged_data[lane_cnt*PRM_DCOEF +: PRM_DCOEF]     = iC_TDATA;
    merged_keep[lane_cnt*LANE_KEEP_W +: LANE_KEEP_W] = {LANE_KEEP_W{1'b1}};
  end

  // A held beat always goes first; no coefficient is accepted while it waits.
  assign load      = pending ? out_free : (beat_done && out_free);
  assign load_data = pending ? gather_data : merged_data;
  assign load_keep = pending ? gather_keep : merged_keep;
  assign load_last = pending ? gather_last : last_coef;

  axis_beat_reg #(
    .DATA_W (PRM_DAXI),
    .KEEP_W (KEEP_W)
  ) u_out (
    .clk       (iSYS_CLK),
    .rst       (iSYS_RST),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .load_last (load_last),
    .valid     (oM_AXIS_TVALID),
    .ready     (iM_AXIS_TREADY),
    .data      (oM_AXIS_TDATA),
    .keep      (oM_AXIS_TKEEP),
    .last      (oM_AXIS_TLAST),
    .free      (out_free)
  );

  always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
    if (iSYS_RST) begin
      state       <= ST_IDLE;
      rem         <= '0;
      lane_cnt    <= '0;
      gather_data <= '0;
      gather_keep <= '0;
      gather_last <= 1'b0;
      pending     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (pending && out_free) begin
        pending     <= 1'b0;
        gather_data <= '0;
        gather_keep <= '0;
        gather_last <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (iCTL_START) begin
            err_r       <= 1'b0;
            lane_cnt    <= '0;
            rem         <= iCTL_LEN;
            pending     <= 1'b0;
            gather_data <= '0;
            gather_keep <= '0;
            gather_last <= 1'b0;
            if (iCTL_LEN == '0) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
            end else begin
              state  <= ST_RUN;
              busy_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            rem <= rem - ONE_LEFT;
            if (iC_TLAST != last_coef) err_r <= 1'b1;
            if (beat_done) begin
              lane_cnt <= '0;
              if (out_free) begin
                gather_data <= '0;
                gather_keep <= '0;
              end else begin
                gather_data <= merged_data;
                gather_keep <= merged_keep;
                gather_last <= last_coef;
                pending     <= 1'b1;
              end
            end else begin
              lane_cnt    <= lane_cnt + 1'b1;
              gather_data <= merged_data;
              gather_keep <= merged_keep;
            end
            if (last_coef) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_fire) begin
            state  <= ST_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oC_TREADY = c_ready;
  assign oCTL_BUSY = busy_r;
  assign oCTL_DONE = done_r;
  assign oCTL_ERR  = err_r;

endmodule

// File: tb/tb_axis_coef_packer.sv
// tb_axis_coef_packer: randomized frames against a queue-based beat model plus literal spot checks.
module tb_axis_coef_packer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] c_len = '0;
  logic        busy, done, err;
  logic        c_valid = 1'b0, c_ready, c_last = 1'b0;
  logic [31:0] c_data = '0;
  logic        m_valid, m_ready = 1'b0, m_last;
  logic [63:0] m_data;
  logic [7:0]  m_keep;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int stall_pct = 0;
  int first_acc_cyc = 0;
  int last_beat_cyc = 0;
  logic [31:0] coefs [4096];
  beat_t exp_q[$];
  beat_t log_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_coef_packer dut (
    .iSYS_CLK       (clk),
    .iSYS_RST       (rst),
    .iCTL_START     (start),
    .iCTL_LEN       (c_len),
    .oCTL_BUSY      (busy),
    .oCTL_DONE      (done),
    .oCTL_ERR       (err),
    .iC_TVALID      (c_valid),
    .oC_TREADY      (c_ready),
    .iC_TDATA       (c_data),
    .iC_TLAST       (c_last),
    .oM_AXIS_TVALID (m_valid),
    .iM_AXIS_TREADY (m_ready),
    .oM_AXIS_TDATA  (m_data),
    .oM_AXIS_TKEEP  (m_keep),
    .oM_AXIS_TLAST  (m_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame model: coefficient i lands in beat i/2, lane i%2; unfilled lanes zero.
  task automatic build_model(input int len);
    int nb;
    beat_t b;
    nb = (len + 1) / 2;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int ln = 0; ln < 2; ln++) begin
        if (bi * 2 + ln < len) begin
          b.d[ln*32 +: 32] = coefs[bi*2 + ln];
          b.k[ln*4 +: 4]   = 4'hF;
        end
      end
      b.l = (bi == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic gen_coefs(input int len, input int mode);
    for (int i = 0; i < len; i++) begin
      case (mode)
        1:       coefs[i] = 32'(-(i + 1));
        2:       coefs[i] = 32'(i + 1);
        default: coefs[i] = $urandom;
      endcase
    end
  endtask

  task automatic run_frame(input int len, input int tlast_idx, input int valid_pct,
                           input int max_acc, input int restart_at);
    int idx;
    int t;
    logic acc;
    log_q.delete();
    build_model(len);
    @(posedge clk); #1;
    start = 1'b1;
    c_len = 13'(len);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    t = 0;
    while (idx < len && idx < max_acc && t < len * 20 + 200) begin
      c_valid = ($urandom_range(99) < valid_pct);
      c_data  = coefs[idx];
      c_last  = (idx == tlast_idx);
      if (t == restart_at) begin
        start = 1'b1;
        c_len = 13'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      acc = c_valid && c_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (idx == 0) first_acc_cyc = cyc;
        idx++;
      end
      t++;
    end
    start   = 1'b0;
    c_valid = 1'b0;
    c_last  = 1'b0;
    if (max_acc < len) begin
      chk("feed_partial", 64'(idx), 64'(max_acc));
    end else begin
      chk("feed_complete", 64'(idx), 64'(len));
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!done && t < 2000);
      chk("done_seen", {63'd0, done}, 64'd1);
      @(negedge clk);
      chk("done_single", {63'd0, done}, 64'd0);
      chk("model_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {60'd0, busy, done, err, c_ready}, 64'd0);
    chk({tag, "_mvalid"}, {62'd0, m_valid, m_last}, 64'd0);
    chk({tag, "_mdata"}, m_data, 64'd0);
    chk({tag, "_mkeep"}, {56'd0, m_keep}, 64'd0);
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk); #1;
      m_ready = ($urandom_range(99) >= stall_pct);
    end
  end

  initial begin : monitor
    beat_t b;
    beat_t e;
    beat_t prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        chk("tready_outside_busy", {63'd0, c_ready && !busy}, 64'd0);
        if (prev_stall) begin
          chk("hold_valid", {63'd0, m_valid}, 64'd1);
          chk("hold_data", m_data, prev.d);
          chk("hold_keep_last", {55'd0, m_keep, m_last}, {55'd0, prev.k, prev.l});
        end
        if (m_valid && m_ready) begin
          b = {m_data, m_keep, m_last};
          log_q.push_back(b);
          if (m_last) last_beat_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e.d);
            chk("beat_keep", {56'd0, m_keep}, {56'd0, e.k});
            chk("beat_last", {63'd0, m_last}, {63'd0, e.l});
          end
        end
        prev_stall = m_valid && !m_ready;
        prev = {m_data, m_keep, m_last};
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int d0;
    int n;
    int len;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); #2;
    rst = 1'b0;

    // NTT frame: coefficients -1,-2,... at full rate
    stall_pct = 0;
    gen_coefs(4096, 1);
    d0 = done_cnt;
    run_frame(4096, 4095, 100, 99999, -1);
    chk("ntt_beats", 64'(log_q.size()), 64'd2048);
    chk("ntt_beat0", log_q[0].d, 64'hFFFFFFFE_FFFFFFFF);
    n = 0;
    foreach (log_q[i]) if (log_q[i].k != 8'hFF || (log_q[i].l && i != 2047)) n++;
    chk("ntt_keep_last_shape", 64'(n), 64'd0);
    chk("ntt_last_flag", {63'd0, log_q[2047].l}, 64'd1);
    chk("ntt_latency_ok", {63'd0, (last_beat_cyc - first_acc_cyc) <= 4098}, 64'd1);
    chk("ntt_err", {63'd0, err}, 64'd0);
    chk("ntt_done_count", 64'(done_cnt - d0), 64'd1);

    // odd length, literal beat values
    gen_coefs(5, 2);
    run_frame(5, 4, 100, 99999, -1);
    chk("odd_beats", 64'(log_q.size()), 64'd3);
    chk("odd_b0", log_q[0].d, 64'h00000002_00000001);
    chk("odd_b1", log_q[1].d, 64'h00000004_00000003);
    chk("odd_b2", log_q[2].d, 64'h00000000_00000005);
    chk("odd_b2_keep", {56'd0, log_q[2].k}, 64'h0F);
    chk("odd_b2_last", {63'd0, log_q[2].l}, 64'd1);

    // backpressure on 10% of cycles, random data
    stall_pct = 10;
    gen_coefs(2048, 0);
    run_frame(2048, 2047, 80, 99999, -1);
    chk("bp_beats", 64'(log_q.size()), 64'd1024);
    chk("bp_err", {63'd0, err}, 64'd0);

    // premature input TLAST on coefficient 3
    stall_pct = 30;
    gen_coefs(8, 0);
    run_frame(8, 3, 90, 99999, -1);
    chk("mis_err", {63'd0, err}, 64'd1);
    chk("mis_beats", 64'(log_q.size()), 64'd4);
    chk("mis_last_b3", {62'd0, log_q[3].l, log_q[2].l}, 64'b10);
    gen_coefs(2, 0);
    run_frame(2, 1, 100, 99999, -1);
    chk("mis_err_cleared", {63'd0, err}, 64'd0);

    // reset after 100 accepts
    stall_pct = 0;
    gen_coefs(2048, 0);
    run_frame(2048, 2047, 100, 100, -1);
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    @(negedge clk); #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    gen_coefs(4, 0);
    run_frame(4, 3, 100, 99999, -1);
    chk("post_reset_beats", 64'(log_q.size()), 64'd2);

    // LEN=0 goes straight to DONE
    log_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    c_len = 13'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", {62'd0, done, busy}, 64'b10);
    @(negedge clk);
    chk("len0_done_drop", {63'd0, done}, 64'd0);
    repeat (4) @(negedge clk);
    chk("len0_no_beats", 64'(log_q.size()), 64'd0);

    // START during RUN is ignored
    gen_coefs(6, 0);
    run_frame(6, 5, 100, 99999, 2);
    chk("restart_beats", 64'(log_q.size()), 64'd3);

    // random short frames
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(40, 1);
      stall_pct = $urandom_range(40);
      gen_coefs(len, 0);
      d0 = done_cnt;
      run_frame(len, len - 1, $urandom_range(100, 50), 99999, -1);
      chk("rnd_beats", 64'(log_q.size()), 64'((len + 1) / 2));
      chk("rnd_err", {63'd0, err}, 64'd0);
      chk("rnd_done_count", 64'(done_cnt - d0), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
